// File: rtl/rand_gen_pkg.sv
// Shared types and constants for the random number generator: FSM states,
// Galois LFSR tap masks and the tap selector used by the LFSR sub-module.
package rand_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    // Wide enough for the largest legal MAX_TRIES (15).
    localparam int TRIES_W = 4;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    function automatic logic [31:0] taps_for(input int lfsr_w);
        logic [31:0] taps;
        taps = '0;
        case (lfsr_w)
            8:       taps = {24'h000000, TAPS_8};
            16:      taps = {16'h0000, TAPS_16};
            32:      taps = TAPS_32;
            default: taps = '0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR. Advances when asked; a load takes priority over
// the advance and a zero load value falls back to SEED so the register never locks up.
module lfsr_galois
    import rand_gen_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(taps_for(LFSR_W));

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic [LFSR_W-1:0] w_load_val;

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    assign w_load_val  = (load_val == '0) ? SEED : load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (load) begin
            r_lfsr <= w_load_val;
        end else if (advance) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    assign state = r_lfsr;

endmodule

// File: rtl/rand_number_gen.sv
// Draws one value in 0..limit per request from a free-running LFSR using
// rejection sampling with a bounded-retry fallback. Optional macro: RAND_NO_REPEAT_EN.
module rand_number_gen
    import rand_gen_pkg::*;
#(
    parameter int                WIDTH     = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    parameter int                MAX_TRIES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req,
    input  logic [WIDTH-1:0]  limit,
    output logic              busy,
    output logic              valid,
    output logic [WIDTH-1:0]  result
);

    // Handshake: req/limit are taken only while busy=0 and enable=1; busy stays
    // high until the draw resolves; valid pulses for exactly one cycle with the
    // new result, and a req in that cycle starts the next draw.

    logic [LFSR_W-1:0]  w_lfsr;
    logic [WIDTH-1:0]   w_cand;
    logic               w_accept_cand;
    logic [WIDTH-1:0]   w_fallback;
    logic               w_last_try;

    state_t             r_state;
    state_t             w_state_next;
    logic [TRIES_W-1:0] r_tries;
    logic [TRIES_W-1:0] w_tries_next;
    logic [WIDTH-1:0]   r_limit_q;
    logic [WIDTH-1:0]   w_limit_next;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_next;
    logic               r_valid;
    logic               w_valid_next;

    lfsr_galois #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .advance  (enable),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (w_lfsr)
    );

    assign w_cand     = WIDTH'(w_lfsr);
    assign w_last_try = (r_tries == TRIES_W'(MAX_TRIES - 1));

`ifdef RAND_NO_REPEAT_EN
    logic             w_in_range;
    logic             w_repeat;
    logic             w_limit_zero;
    logic [WIDTH-1:0] w_fb_raw;
    logic [WIDTH:0]   w_fb_plus;
    logic [WIDTH-1:0] w_fb_bump;

    // A zero limit leaves no alternative, so repeating 0 is allowed there.
    assign w_limit_zero  = (r_limit_q == '0);
    assign w_in_range    = (w_cand <= r_limit_q);
    assign w_repeat      = (w_cand == r_result) && !w_limit_zero;
    assign w_accept_cand = w_in_range && !w_repeat;

    assign w_fb_raw   = w_cand & r_limit_q;
    assign w_fb_plus  = {1'b0, r_result} + (WIDTH + 1)'(1);
    assign w_fb_bump  = (w_fb_plus > {1'b0, r_limit_q}) ? '0 : w_fb_plus[WIDTH-1:0];
    assign w_fallback = ((w_fb_raw == r_result) && !w_limit_zero) ? w_fb_bump : w_fb_raw;
`else
    assign w_accept_cand = (w_cand <= r_limit_q);
    assign w_fallback    = w_cand & r_limit_q;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_tries_next  = r_tries;
        w_limit_next  = r_limit_q;
        w_result_next = r_result;
        w_valid_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req && enable) begin
                    w_limit_next = limit;
                    w_tries_next = '0;
                    w_state_next = DRAW;
                end
            end
            DRAW: begin
                if (enable) begin
                    if (w_accept_cand) begin
                        w_result_next = w_cand;
                        w_valid_next  = 1'b1;
                        w_state_next  = IDLE;
                    end else if (w_last_try) begin
                        w_result_next = w_fallback;
                        w_valid_next  = 1'b1;
                        w_state_next  = IDLE;
                    end else begin
                        w_tries_next = r_tries + TRIES_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tries   <= '0;
            r_limit_q <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tries   <= w_tries_next;
            r_limit_q <= w_limit_next;
            r_result  <= w_result_next;
            r_valid   <= w_valid_next;
        end
    end

    assign busy   = (r_state == DRAW);
    assign valid  = r_valid;
    assign result = r_result;

endmodule

// File: tb/tb_rand_number_gen.sv
// Bench for rand_number_gen: directed draws with a result/latency scoreboard
// checked by an independent monitor on every valid pulse.
module tb_rand_number_gen;
    import rand_gen_pkg::*;

    localparam int          WIDTH     = 4;
    localparam int          LFSR_W    = 16;
    localparam int          MAX_TRIES = 4;
    localparam logic [15:0] SEED      = 16'hACE1;
`ifdef RAND_NO_REPEAT_EN
    localparam bit HAND_OK = 1'b0;
`else
    localparam bit HAND_OK = 1'b1;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic [3:0]  limit;
    logic        busy;
    logic        valid;
    logic [3:0]  result;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rand_number_gen #(
        .WIDTH     (WIDTH),
        .LFSR_W    (LFSR_W),
        .SEED      (SEED),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .limit     (limit),
        .busy      (busy),
        .valid     (valid),
        .result    (result)
    );

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    logic [3:0]  m_prev;

    function automatic logic [15:0] step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)            m_lfsr <= SEED;
        else if (seed_load) m_lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
        else if (enable)    m_lfsr <= step(m_lfsr);
    end

    task automatic predict(input logic [15:0] start, input logic [3:0] lim,
                           input logic [3:0] prev, output logic [3:0] res, output int lat);
        logic [15:0] l;
        logic [3:0]  c;
        bit          ok;
        bit          done;
        int          p1;
        l = start; done = 0; res = '0; lat = 0;
        p1 = int'(prev) + 1;
        for (int k = 0; k < MAX_TRIES; k++) begin
            if (!done) begin
                c  = l[3:0];
                ok = (c <= lim);
`ifdef RAND_NO_REPEAT_EN
                if (lim != 0 && c == prev) ok = 0;
`endif
                if (ok) begin
                    res = c; lat = k + 2; done = 1;
                end else if (k == MAX_TRIES - 1) begin
                    res = c & lim;
`ifdef RAND_NO_REPEAT_EN
                    if (lim != 0 && res == prev) res = (p1 > int'(lim)) ? 4'd0 : 4'(p1);
`endif
                    lat = MAX_TRIES + 1; done = 1;
                end
                l = step(l);
            end
        end
        if (p1 < 0) res = '0;
    endtask

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    int               issue_q[$];
    int               lat_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [3:0] mon_exp;
    int         mon_issue;
    int         mon_lat;
    int         mon_got_lat;

    always @(negedge clk) begin
        if (!rst && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_exp     = exp_q.pop_front();
                mon_issue   = issue_q.pop_front();
                mon_lat     = lat_q.pop_front();
                mon_got_lat = cyc - mon_issue;
                check("result", 32'(result), 32'(mon_exp));
                check("latency", 32'(mon_got_lat), 32'(mon_lat));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle (or in its valid cycle), enable=1.
    task automatic issue(input logic [3:0] lim, input bit ld, input logic [15:0] sv,
                         input bit hand, input logic [3:0] hand_res, input int extra_lat);
        logic [15:0] start;
        logic [3:0]  r;
        int          lat;
        start = ld ? ((sv == 16'h0000) ? SEED : sv) : step(m_lfsr);
        predict(start, lim, m_prev, r, lat);
        if (hand) r = hand_res;
        m_prev = r;
        exp_q.push_back(r);
        issue_q.push_back(cyc);
        lat_q.push_back(lat + extra_lat);
        req       = 1'b1;
        limit     = lim;
        seed_load = ld;
        seed_in   = sv;
    endtask

    // Drives junk req/limit while busy; returns at the negedge where valid is seen.
    task automatic wait_valid();
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            req   = 1'($urandom_range(0, 1));
            limit = 4'($urandom_range(0, 15));
            tick();
            n++;
        end
        if (valid !== 1'b1) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic draws(input logic [3:0] lim, input int count);
        for (int i = 0; i < count; i++) begin
            issue(lim, 1'b0, 16'h0000, 1'b0, 4'd0, 0);
            tick();
            seed_load = 1'b0;
            wait_valid();
        end
        req   = 1'b0;
        limit = lim;
    endtask

    // ---------------- stimulus ----------------
    int saw_valid;

    initial begin
        rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = '0;
        req = 1'b0; limit = '0; m_prev = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_lfsr", 32'(dut.w_lfsr), 32'hACE1);

        rst = 1'b0;
        req = 1'b1; limit = 4'd15;
        tick();
        check("req_disabled_ignored", 32'(busy), 32'd0);
        check("lfsr_hold_disabled", 32'(dut.w_lfsr), 32'hACE1);
        req = 1'b0;

        enable = 1'b1;
        tick();
        check("lfsr_first_step", 32'(dut.w_lfsr), 32'hE270);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_result", 32'(result), 32'd0);

        // First draw: DRAW entry lfsr is 16'h7138, candidate 8, latency 2.
        issue(4'd15, 1'b0, 16'h0000, 1'b1, 4'd8, 0);
        tick();
        check("draw_busy", 32'(busy), 32'd1);
        check("draw_entry_lfsr", 32'(dut.w_lfsr), 32'h7138);
        wait_valid();
        req = 1'b0;

        draws(4'd15, 8);
        draws(4'd0, 20);
        draws(4'd5, 1000);

        // Seed 005E gives candidates 14,15,7,11: fallback 11 & 5 = 1.
        issue(4'd5, 1'b1, 16'h005E, HAND_OK, 4'd1, 0);
        tick();
        seed_load = 1'b0;
        wait_valid();
        req = 1'b0;

        // Same draw with a 10-cycle enable pause after two rejections.
        issue(4'd5, 1'b1, 16'h005E, HAND_OK, 4'd1, 10);
        tick();
        seed_load = 1'b0; req = 1'b0;
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req   = 1'($urandom_range(0, 1));
            limit = 4'($urandom_range(0, 15));
            tick();
        end
        check("pause_lfsr", 32'(dut.w_lfsr), 32'hB417);
        check("pause_state", 32'(dut.r_state), 32'(DRAW));
        check("pause_busy", 32'(busy), 32'd1);
        check("pause_tries", 32'(dut.r_tries), 32'd2);
        enable = 1'b1;
        wait_valid();
        req = 1'b0;

        seed_load = 1'b1; seed_in = 16'h0000;
        tick();
        seed_load = 1'b0;
        check("zero_seed_load", 32'(dut.w_lfsr), 32'hACE1);

        // Reset in the middle of a draw that would need four tries.
        req = 1'b1; limit = 4'd5; seed_load = 1'b1; seed_in = 16'h007F;
        tick();
        req = 1'b0; seed_load = 1'b0;
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_lfsr", 32'(dut.w_lfsr), 32'hACE1);
        m_prev = '0;
        tick();
        tick();
        rst = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid === 1'b1) saw_valid = 1;
        end
        check("no_valid_after_rst", 32'(saw_valid), 32'd0);

`ifdef RAND_NO_REPEAT_EN
        for (int i = 0; i < 6; i++) begin
            issue(4'd1, 1'b0, 16'h0000, 1'b1, (i % 2 == 0) ? 4'd1 : 4'd0, 0);
            tick();
            wait_valid();
        end
        req = 1'b0;
`endif

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
